// File: rtl/vga_pkg.sv
// Shared definitions for the VGA receive-side frame monitor.
// Contents:
//   - 640x480@60 raster timing (active, porch, sync and total widths)
//   - counter width and saturating increment helper
//   - bit positions inside frame_err
//   - monitor FSM state enum
package vga_pkg;

    // Horizontal timing in pixel ticks.
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 800

    // Vertical timing in lines.
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 525

    localparam int CHK_W    = 16;

    // Raster counters must hold 2*H_TOTAL and 2*V_TOTAL (the lock-loss limits).
    localparam int CNT_W    = 12;

    // frame_err = {vtotal_err, htotal_err, active_err}
    localparam int ERR_ACTIVE = 0;
    localparam int ERR_HTOTAL = 1;
    localparam int ERR_VTOTAL = 2;

    typedef enum logic {
        SEEK   = 1'b0,
        LOCKED = 1'b1
    } mon_state_e;

    // Raster counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/vga_frame_monitor_if.sv
// Bundle between the tapped VGA pins and the frame monitor.
// master: whatever drives the VGA pins (board tap or test driver); it reads results.
// slave : the monitor; it samples the pins and drives results.
// Pins   : VGA_CLK, VGA_HS (active low), VGA_VS (active low), VGA_BLANK_N, VGA_R/G/B.
// Results: pix_x/pix_y/pix_valid (per active pixel), locked, frame_done,
//          frame_checksum, frame_err, frame_count, mon_state (FSM state for debug).
// The result strobes (pix_valid, frame_done) are single-cycle qualifiers with no
// backpressure: a consumer must take the accompanying data in that same cycle.
interface vga_frame_monitor_if #(
    parameter int CFG_CHK_W = vga_pkg::CHK_W
);
    import vga_pkg::*;

    logic                 VGA_CLK;
    logic                 VGA_HS;
    logic                 VGA_VS;
    logic                 VGA_BLANK_N;
    logic [7:0]           VGA_R;
    logic [7:0]           VGA_G;
    logic [7:0]           VGA_B;

    logic [9:0]           pix_x;
    logic [9:0]           pix_y;
    logic                 pix_valid;
    logic                 locked;
    logic                 frame_done;
    logic [CFG_CHK_W-1:0] frame_checksum;
    logic [2:0]           frame_err;
    logic [15:0]          frame_count;
    mon_state_e           mon_state;

    modport master (
        output VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B,
        input  pix_x, pix_y, pix_valid, locked, frame_done,
               frame_checksum, frame_err, frame_count, mon_state
    );

    modport slave (
        input  VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B,
        output pix_x, pix_y, pix_valid, locked, frame_done,
               frame_checksum, frame_err, frame_count, mon_state
    );

endinterface

// File: rtl/vga_sync_edge.sv
// Pixel-clock tick and sync-edge detector for the frame monitor.
// Ports:
//   clk_i, rst_ni       system clock, async active-low reset
//   vga_clk_i           pixel clock (synchronous to clk_i, half rate)
//   hs_i, vs_i          active-low syncs
//   blank_n_i, msb_i    active flag and {R[7],G[7],B[7]}
//   tick_o              one cycle per pixel-clock rising edge (registered)
//   hs_fall_o/vs_fall_o sync fell on this tick (qualified by tick_o)
//   blank_n_o, msb_o    pixel data sampled on that tick
module vga_sync_edge (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       vga_clk_i,
    input  logic       hs_i,
    input  logic       vs_i,
    input  logic       blank_n_i,
    input  logic [2:0] msb_i,
    output logic       tick_o,
    output logic       hs_fall_o,
    output logic       vs_fall_o,
    output logic       blank_n_o,
    output logic [2:0] msb_o
);

    logic       vga_clk_q;
    logic       tick;
    logic       hs_last_q;
    logic       vs_last_q;
    logic       tick_q;
    logic       hs_fall_q;
    logic       vs_fall_q;
    logic       blank_n_q;
    logic [2:0] msb_q;

    assign tick = vga_clk_i & ~vga_clk_q;

    // The last sync samples reset low, so a fall needs a genuine high sample
    // after reset first.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vga_clk_q <= 1'b0;
            hs_last_q <= 1'b0;
            vs_last_q <= 1'b0;
            tick_q    <= 1'b0;
            hs_fall_q <= 1'b0;
            vs_fall_q <= 1'b0;
            blank_n_q <= 1'b0;
            msb_q     <= 3'b000;
        end else begin
            vga_clk_q <= vga_clk_i;
            tick_q    <= tick;
            if (tick) begin
                hs_fall_q <= hs_last_q & ~hs_i;
                vs_fall_q <= vs_last_q & ~vs_i;
                hs_last_q <= hs_i;
                vs_last_q <= vs_i;
                blank_n_q <= blank_n_i;
                msb_q     <= msb_i;
            end else begin
                hs_fall_q <= 1'b0;
                vs_fall_q <= 1'b0;
            end
        end
    end

    assign tick_o    = tick_q;
    assign hs_fall_o = hs_fall_q;
    assign vs_fall_o = vs_fall_q;
    assign blank_n_o = blank_n_q;
    assign msb_o     = msb_q;

endmodule

// File: rtl/vga_frame_monitor.sv
// VGA receive-side frame monitor: recovers pixel coordinates from tapped VGA
// pins, checks line/frame timing against the raster and produces a per-frame
// checksum of the colour MSBs for loopback self-test.
// Ports:
//   CLOCK_50  system clock, all logic on posedge
//   RESET_N   asynchronous active-low reset
//   bus       vga_frame_monitor_if.slave (VGA pins in, results out)
module vga_frame_monitor #(
    parameter int CFG_H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int CFG_H_TOTAL  = vga_pkg::H_TOTAL,
    parameter int CFG_V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int CFG_V_TOTAL  = vga_pkg::V_TOTAL,
    parameter int CFG_CHK_W    = vga_pkg::CHK_W
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET_N,
    vga_frame_monitor_if.slave    bus
);
    import vga_pkg::*;

    localparam logic [CNT_W-1:0] H_ACT_C   = CNT_W'(CFG_H_ACTIVE);
    localparam logic [CNT_W-1:0] H_TOT_C   = CNT_W'(CFG_H_TOTAL);
    localparam logic [CNT_W-1:0] V_ACT_C   = CNT_W'(CFG_V_ACTIVE);
    localparam logic [CNT_W-1:0] V_TOT_C   = CNT_W'(CFG_V_TOTAL);
    localparam logic [CNT_W-1:0] H_LIMIT_C = CNT_W'(2 * CFG_H_TOTAL);
    localparam logic [CNT_W-1:0] V_LIMIT_C = CNT_W'(2 * CFG_V_TOTAL);

    logic       ev_tick;
    logic       ev_hs_fall;
    logic       ev_vs_fall;
    logic       ev_blank_n;
    logic [2:0] ev_msb;

    vga_sync_edge u_sync_edge (
        .clk_i     (CLOCK_50),
        .rst_ni    (RESET_N),
        .vga_clk_i (bus.VGA_CLK),
        .hs_i      (bus.VGA_HS),
        .vs_i      (bus.VGA_VS),
        .blank_n_i (bus.VGA_BLANK_N),
        .msb_i     ({bus.VGA_R[7], bus.VGA_G[7], bus.VGA_B[7]}),
        .tick_o    (ev_tick),
        .hs_fall_o (ev_hs_fall),
        .vs_fall_o (ev_vs_fall),
        .blank_n_o (ev_blank_n),
        .msb_o     (ev_msb)
    );

    // Only the colour MSBs enter the checksum.
    logic unused_colour_lsbs;
    assign unused_colour_lsbs = ^{bus.VGA_R[6:0], bus.VGA_G[6:0], bus.VGA_B[6:0]};

    mon_state_e           state_q, state_d;
    logic [CNT_W-1:0]     h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0]     lines_q, lines_d;
    logic [CNT_W-1:0]     act_lines_q, act_lines_d;
    logic [CNT_W-1:0]     line_pix_q, line_pix_d;
    logic [CFG_CHK_W-1:0] csum_q, csum_d;
    logic [2:0]           err_q, err_d;
    logic [2:0]           close_err;

    logic [9:0]           pix_x_q, pix_x_d;
    logic [9:0]           pix_y_q, pix_y_d;
    logic                 pix_valid_q, pix_valid_d;
    logic                 locked_q;
    logic                 frame_done_q, frame_done_d;
    logic [CFG_CHK_W-1:0] frame_csum_q, frame_csum_d;
    logic [2:0]           frame_err_q, frame_err_d;
    logic [15:0]          frame_count_q, frame_count_d;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q       <= SEEK;
            h_cnt_q       <= '0;
            lines_q       <= '0;
            act_lines_q   <= '0;
            line_pix_q    <= '0;
            csum_q        <= '0;
            err_q         <= '0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_valid_q   <= 1'b0;
            locked_q      <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_csum_q  <= '0;
            frame_err_q   <= '0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            h_cnt_q       <= h_cnt_d;
            lines_q       <= lines_d;
            act_lines_q   <= act_lines_d;
            line_pix_q    <= line_pix_d;
            csum_q        <= csum_d;
            err_q         <= err_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_valid_q   <= pix_valid_d;
            // locked follows the state register by one cycle.
            locked_q      <= (state_q == LOCKED);
            frame_done_q  <= frame_done_d;
            frame_csum_q  <= frame_csum_d;
            frame_err_q   <= frame_err_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Events inside one tick are applied in order: line close, frame close,
    // active pixel, lock-loss check. A pixel on a frame-closing tick therefore
    // belongs to the new frame.
    always_comb begin
        state_d       = state_q;
        h_cnt_d       = h_cnt_q;
        lines_d       = lines_q;
        act_lines_d   = act_lines_q;
        line_pix_d    = line_pix_q;
        csum_d        = csum_q;
        err_d         = err_q;
        close_err     = 3'b000;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        pix_valid_d   = 1'b0;
        frame_done_d  = 1'b0;
        frame_csum_d  = frame_csum_q;
        frame_err_d   = frame_err_q;
        frame_count_d = frame_count_q;

        case (state_q)
            SEEK: begin
                if (ev_tick && ev_vs_fall) begin
                    state_d     = LOCKED;
                    h_cnt_d     = CNT_W'(1);
                    lines_d     = '0;
                    act_lines_d = '0;
                    line_pix_d  = '0;
                    csum_d      = '0;
                    err_d       = '0;
                end
            end
            LOCKED: begin
                if (ev_tick) begin
                    h_cnt_d = sat_inc(h_cnt_q);

                    if (ev_hs_fall) begin
                        if (h_cnt_q != H_TOT_C) begin
                            err_d[ERR_HTOTAL] = 1'b1;
                        end
                        if (line_pix_q != '0) begin
                            act_lines_d = sat_inc(act_lines_q);
                            if (line_pix_q != H_ACT_C) begin
                                err_d[ERR_ACTIVE] = 1'b1;
                            end
                        end
                        lines_d    = sat_inc(lines_q);
                        h_cnt_d    = CNT_W'(1);
                        line_pix_d = '0;
                    end

                    if (ev_vs_fall) begin
                        close_err = err_d;
                        if (lines_d != V_TOT_C) begin
                            close_err[ERR_VTOTAL] = 1'b1;
                        end
                        if (act_lines_d != V_ACT_C) begin
                            close_err[ERR_ACTIVE] = 1'b1;
                        end
                        frame_done_d  = 1'b1;
                        frame_csum_d  = csum_d;
                        frame_err_d   = close_err;
                        frame_count_d = frame_count_q + 16'd1;
                        lines_d       = '0;
                        act_lines_d   = '0;
                        csum_d        = '0;
                        err_d         = '0;
                    end

                    if (ev_blank_n) begin
                        pix_valid_d = 1'b1;
                        pix_x_d     = line_pix_d[9:0];
                        pix_y_d     = act_lines_d[9:0];
                        line_pix_d  = sat_inc(line_pix_d);
                        csum_d      = csum_d + CFG_CHK_W'(ev_msb);
                    end

                    // Raster lost: discard the partial frame and hold the
                    // previous frame results.
                    if (h_cnt_d >= H_LIMIT_C || lines_d >= V_LIMIT_C) begin
                        state_d       = SEEK;
                        frame_done_d  = 1'b0;
                        frame_csum_d  = frame_csum_q;
                        frame_err_d   = frame_err_q;
                        frame_count_d = frame_count_q;
                        h_cnt_d       = '0;
                        lines_d       = '0;
                        act_lines_d   = '0;
                        line_pix_d    = '0;
                        csum_d        = '0;
                        err_d         = '0;
                    end
                end
            end
            default: begin
                state_d = SEEK;
            end
        endcase
    end

    assign bus.pix_x          = pix_x_q;
    assign bus.pix_y          = pix_y_q;
    assign bus.pix_valid      = pix_valid_q;
    assign bus.locked         = locked_q;
    assign bus.frame_done     = frame_done_q;
    assign bus.frame_checksum = frame_csum_q;
    assign bus.frame_err      = frame_err_q;
    assign bus.frame_count    = frame_count_q;
    assign bus.mon_state      = state_q;

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Bench for vga_frame_monitor on a scaled-down raster (16x6 visible inside
// 20x10 total) so that full frames, lock loss and reset recovery fit in a
// short run. Checksum width 8 makes a white frame wrap the sum.
module tb_vga_frame_monitor;

  localparam int H_ACT = 16;
  localparam int H_TOT = 20;
  localparam int V_ACT = 6;
  localparam int V_TOT = 10;
  localparam int CHK   = 8;

  // clock / reset
  logic clk = 1'b0;
  logic RESET_N;
  always #5 clk = ~clk;

  vga_frame_monitor_if #(.CFG_CHK_W(CHK)) bus ();

  vga_frame_monitor #(
    .CFG_H_ACTIVE (H_ACT),
    .CFG_H_TOTAL  (H_TOT),
    .CFG_V_ACTIVE (V_ACT),
    .CFG_V_TOTAL  (V_TOT),
    .CFG_CHK_W    (CHK)
  ) dut (
    .CLOCK_50 (clk),
    .RESET_N  (RESET_N),
    .bus      (bus)
  );

  int n_compared = 0;
  int n_mismatched = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: frame-level bookkeeping
  logic [19:0] exp_pix_q[$];    // {y, x}
  logic [26:0] exp_frame_q[$];  // {count, err, checksum}
  bit m_locked = 1'b0;
  int m_lines, m_act, m_csum, m_count, m_pushed;
  bit m_herr, m_aerr;
  int n_done = 0;

  // driver tasks
  task automatic drive_tick(input bit hs, input bit vs, input bit bl,
                            input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    @(negedge clk);
    bus.VGA_CLK = 1'b0;
    bus.VGA_HS = hs;
    bus.VGA_VS = vs;
    bus.VGA_BLANK_N = bl;
    bus.VGA_R = r;
    bus.VGA_G = g;
    bus.VGA_B = b;
    @(negedge clk);
    bus.VGA_CLK = 1'b1;
  endtask

  // One line: HS low for ticks 0..1, back porch tick 2, `act` active pixels
  // from tick 3, then blank up to `len` ticks. mode 0 random, 1 white, 2 black.
  task automatic drive_line(input int len, input int act, input bit sof,
                            input bit vs_low, input int mode);
    logic [7:0] r, g, b;
    logic [2:0] e;
    bit bl;
    if (sof) begin
      if (m_locked) begin
        e[2] = (m_lines != V_TOT);
        e[1] = m_herr;
        e[0] = m_aerr || (m_act != V_ACT);
        m_count = (m_count + 1) % 65536;
        exp_frame_q.push_back({16'(m_count), e, 8'(m_csum % (1 << CHK))});
        m_pushed++;
      end
      m_locked = 1'b1;
      m_lines = 0;
      m_act = 0;
      m_csum = 0;
      m_herr = 1'b0;
      m_aerr = 1'b0;
    end
    for (int t = 0; t < len; t++) begin
      bl = (t >= 3) && (t < 3 + act);
      case (mode)
        1: begin r = 8'hFF; g = 8'hFF; b = 8'hFF; end
        2: begin r = 8'h00; g = 8'h00; b = 8'h00; end
        default: begin
          r = 8'($urandom_range(0, 255));
          g = 8'($urandom_range(0, 255));
          b = 8'($urandom_range(0, 255));
        end
      endcase
      if (bl && m_locked) begin
        exp_pix_q.push_back({10'(m_act), 10'(t - 3)});
        m_csum += 4 * r[7] + 2 * g[7] + b[7];
      end
      drive_tick(t >= 2, !vs_low, bl, r, g, b);
    end
    if (m_locked) begin
      m_lines++;
      if (len != H_TOT) m_herr = 1'b1;
      if (act > 0) begin
        m_act++;
        if (act != H_ACT) m_aerr = 1'b1;
      end
      if (len >= 2 * H_TOT || m_lines >= 2 * V_TOT) m_locked = 1'b0;
    end
  endtask

  task automatic check_reset_values(input string w);
    check_eq({w, "_pix_valid"}, 32'(bus.pix_valid), 0);
    check_eq({w, "_pix_x"}, 32'(bus.pix_x), 0);
    check_eq({w, "_pix_y"}, 32'(bus.pix_y), 0);
    check_eq({w, "_locked"}, 32'(bus.locked), 0);
    check_eq({w, "_frame_done"}, 32'(bus.frame_done), 0);
    check_eq({w, "_frame_checksum"}, 32'(bus.frame_checksum), 0);
    check_eq({w, "_frame_err"}, 32'(bus.frame_err), 0);
    check_eq({w, "_frame_count"}, 32'(bus.frame_count), 0);
  endtask

  // fault: 0 clean, 1 odd HS period, 2 short active line, 3 missing active
  // line, 4 extra blank line, 5 HS stuck high (lock loss). rst_line >= 0
  // pulses RESET_N just before that line.
  task automatic drive_frame(input int fault, input int fline, input int mode, input int rst_line);
    int nl;
    int len;
    int act;
    nl = (fault == 4) ? V_TOT + 1 : V_TOT;
    for (int l = 0; l < nl; l++) begin
      if (l == rst_line) begin
        repeat (4) @(negedge clk);
        check_eq("pix_q_drained_before_rst", 32'(exp_pix_q.size()), 0);
        check_eq("frame_q_drained_before_rst", 32'(exp_frame_q.size()), 0);
        RESET_N = 1'b0;
        #1;
        check_reset_values("midrst");
        m_locked = 1'b0;
        m_count = 0;
        @(negedge clk);
        @(negedge clk);
        RESET_N = 1'b1;
      end
      len = H_TOT;
      act = (l >= 3 && l < 3 + V_ACT) ? H_ACT : 0;
      if (l == fline) begin
        case (fault)
          1: len = ($urandom_range(0, 1) == 1) ? H_TOT - 1 : H_TOT + 1;
          2: act = H_ACT - 1;
          3: act = 0;
          5: begin len = 3 * H_TOT; act = 0; end
          default: ;
        endcase
      end
      drive_line(len, act, l == 0, l < 2, mode);
      if (fault == 5 && l == fline) check_eq("locked_after_loss", 32'(bus.locked), 0);
    end
  endtask

  // scoreboard monitors, sampled on the falling edge
  logic [19:0] pix_e;
  logic [26:0] frm_e;

  always @(negedge clk) begin
    if (RESET_N && bus.pix_valid) begin
      if (exp_pix_q.size() == 0) begin
        check_eq("pix_unexpected", {12'd0, bus.pix_y, bus.pix_x}, 32'hFFFF_FFFF);
      end else begin
        pix_e = exp_pix_q.pop_front();
        check_eq("pix_yx", {12'd0, bus.pix_y, bus.pix_x}, {12'd0, pix_e});
      end
    end
  end

  always @(negedge clk) begin
    if (RESET_N && bus.frame_done) begin
      n_done++;
      if (exp_frame_q.size() == 0) begin
        check_eq("frame_done_unexpected", 32'(bus.frame_count), 32'hFFFF_FFFF);
      end else begin
        frm_e = exp_frame_q.pop_front();
        check_eq("frame_checksum", 32'(bus.frame_checksum), 32'(frm_e[7:0]));
        check_eq("frame_err", 32'(bus.frame_err), 32'(frm_e[10:8]));
        check_eq("frame_count", 32'(bus.frame_count), 32'(frm_e[26:11]));
        check_eq("locked_at_done", 32'(bus.locked), 1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int fault;
    RESET_N = 1'b0;
    bus.VGA_CLK = 1'b0;
    bus.VGA_HS = 1'b1;
    bus.VGA_VS = 1'b1;
    bus.VGA_BLANK_N = 1'b0;
    bus.VGA_R = 8'h00;
    bus.VGA_G = 8'h00;
    bus.VGA_B = 8'h00;
    m_count = 0;
    m_pushed = 0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    RESET_N = 1'b1;

    // preamble before the first VS fall
    for (int i = 0; i < 3; i++) drive_line(H_TOT, 0, 1'b0, 1'b0, 0);

    // nominal white frames, then black, then directed timing faults
    for (int i = 0; i < 3; i++) drive_frame(0, -1, 1, -1);
    check_eq("locked_nominal", 32'(bus.locked), 1);
    drive_frame(0, -1, 2, -1);
    drive_frame(1, 5, 1, -1);
    drive_frame(0, -1, 1, -1);
    drive_frame(2, 4, 1, -1);

    // randomized frames
    for (int i = 0; i < 8; i++) begin
      fault = $urandom_range(0, 4);
      drive_frame(fault, $urandom_range(3, 3 + V_ACT - 1), $urandom_range(0, 2), -1);
    end

    // lock loss, relock, first result one frame later
    drive_frame(5, 5, 0, -1);
    drive_frame(0, -1, 0, -1);
    check_eq("locked_after_relock", 32'(bus.locked), 1);
    drive_frame(0, -1, 0, -1);

    // reset mid-frame, recovery
    drive_frame(0, -1, 1, 5);
    drive_frame(0, -1, 0, -1);
    drive_frame(0, -1, 1, -1);

    // trailing VS fall closes the last frame
    drive_line(H_TOT, 0, 1'b1, 1'b1, 1);
    drive_line(H_TOT, 0, 1'b0, 1'b1, 1);
    repeat (10) @(negedge clk);

    check_eq("frame_q_empty_at_end", 32'(exp_frame_q.size()), 0);
    check_eq("pix_q_empty_at_end", 32'(exp_pix_q.size()), 0);
    check_eq("frame_done_total", 32'(n_done), 32'(m_pushed));
    check_eq("frame_count_after_reset", 32'(bus.frame_count), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
